// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSBs
  assign w_x       = r_a_sr[0];
  assign w_y       = r_b_sr[0];
  assign w_d       = w_x ^ w_y ^ r_br;
  assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_d;
    end else begin : g_res_wn
      assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      b_out   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_br    <= b_in;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_res  <= w_res_next;
          r_br   <= w_br_next;
          r_cnt  <= r_cnt + 1'b1;
          // Final bit: the cell is processing the operand MSBs
          if (w_last) begin
            diff    <= w_res_next;
            b_out   <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= (w_x ^ w_y) & (w_d ^ w_x);
`endif
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         b_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [W-1:0] exp_diff = '0;
  logic         exp_bout = 1'b0;
  logic         exp_ovf  = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,.ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic; overflow from operand and result sign bits
  task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    int full;
    full     = int'(ia) - int'(ib) - int'(ibin);
    exp_diff = W'(full);
    exp_bout = (int'(ia) < int'(ib) + int'(ibin));
    exp_ovf  = (ia[W-1] ^ ib[W-1]) & (exp_diff[W-1] ^ ia[W-1]);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    check({tag, "_bout"}, 32'(b_out), 32'(exp_bout));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  // Called at a negedge; returns at the negedge after the done edge (or after
  // the idle check when hold=0). With hold=1 start stays high for a back-to-back op.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input bit mid_start, input bit hold);
    int k;
    int extra;
    a = ia; b = ib; b_in = ibin; start = 1'b1;
    @(negedge clk);
    start = hold;
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
    k = 0;
    while (!done && k <= W + 2) begin
      check("busy", 32'(busy), 32'd1);
      if (mid_start && k == 2) start = 1'b1;
      if (mid_start && k == 3) start = 1'b0;
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(W));
    check("done", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    model(ia, ib, ibin);
    check_outputs("result");
    $display("op a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d (expect %02h %0d)",
             ia, ib, ibin, diff, b_out, exp_diff, exp_bout);
    if (!hold) begin
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check_outputs("hold");
      if (mid_start) begin
        extra = 0;
        repeat (W + 2) begin
          @(negedge clk);
          if (done) extra++;
        end
        check("no_extra_done", 32'(extra), 32'd0);
      end
    end
  endtask

  task automatic do_reset_mid(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    int n;
    a = ia; b = ib; b_in = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_diff = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_outputs("rst_mid");
    n = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) n++;
    end
    check("rst_no_done", 32'(n), 32'd0);
    check("rst_idle", 32'(busy), 32'd0);
    $display("reset mid-op a=%02h b=%02h: done pulses after reset=%0d", ia, ib, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hold;
    bit mid;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'h35, 8'h12, 1'b0, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'h10, 8'h0F, 1'b1, 1'b0, 1'b1);
    do_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    do_op(8'h5A, 8'hC3, 1'b1, 1'b1, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    do_op(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      mid  = ($urandom_range(0, 3) == 0);
      hold = !mid && ($urandom_range(0, 1) == 1) && (i != 39);
      do_op(W'($urandom), W'($urandom), 1'($urandom), mid, hold);
    end

    do_reset_mid(8'h35, 8'h12, 1'b0);
    do_op(8'h7F, 8'h80, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
